// File: rtl/clken_pkg.sv
// Shared types and defaults for the clock-enable divider bank.
// The sync FSM is only built when CLKEN_SYNC_EN is defined.
package clken_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } sync_state_t;

  localparam int DIV_W_DEF       = 3;
  localparam int NUM_MATCH_DEF   = 2;
  localparam int RESET_PHASE_DEF = 4;

  // Upper bounds for the generic slot extractor below.
  localparam int MAX_DIV_W      = 16;
  localparam int MAX_MATCH_BITS = 256;

  function automatic logic [MAX_DIV_W-1:0] match_slot(
    input logic [MAX_MATCH_BITS-1:0] vals,
    input int unsigned               slot,
    input int unsigned               w
  );
    logic [MAX_MATCH_BITS-1:0] shifted;
    logic [MAX_MATCH_BITS-1:0] mask;
    shifted = vals >> (slot * w);
    mask    = (MAX_MATCH_BITS'(1) << w) - MAX_MATCH_BITS'(1);
    return MAX_DIV_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/clken_sync_fsm.sv
// Realign handshake: IDLE -> PEND on request, load on the next CE_IN_N,
// then a one-cycle ack. Instantiated only when CLKEN_SYNC_EN is defined.
//
// state | meaning
// IDLE  | no realign in progress, sampling sync_req
// PEND  | waiting for the next ce_in_n to load the phase
// ACK   | counter holds the new phase, sync_ack high this cycle
module clken_sync_fsm
  import clken_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ce_in_n,
  input  logic sync_req,
  output logic load,
  output logic sync_ack
);

  sync_state_t state;

  // Load must act on the same cycle as the CE_IN_N, so it is decoded, not registered.
  assign load = (state == ST_PEND) & ce_in_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sync_ack <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sync_ack <= 1'b0;
          if (sync_req) state <= ST_PEND;
        end
        ST_PEND: begin
          if (ce_in_n) begin
            state    <= ST_ACK;
            sync_ack <= 1'b1;
          end
        end
        ST_ACK: begin
          sync_ack <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          sync_ack <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/clken_divider_bank.sv
// Clock-enable divider bank: binary divider taps, phase-match enables, toggle
// clock and slow level. Runtime realign is present only with CLKEN_SYNC_EN.
module clken_divider_bank
  import clken_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int NUM_MATCH   = NUM_MATCH_DEF,
  parameter int RESET_PHASE = RESET_PHASE_DEF
) (
  input  logic                       CLK,
  input  logic                       RESETP,
  input  logic                       CE_IN_P,
  input  logic                       CE_IN_N,
  input  logic                       SYNC_REQ,
  input  logic [DIV_W-1:0]           SYNC_PHASE,
  output logic                       SYNC_ACK,
  input  logic [NUM_MATCH*DIV_W-1:0] MATCH_VAL,
  output logic [DIV_W-1:0]           DIV_CNT,
  output logic [DIV_W-1:0]           EN_RISE,
  output logic [DIV_W-1:0]           EN_FALL,
  output logic [NUM_MATCH-1:0]       MATCH_EN,
  output logic                       TGL_CLK,
  output logic                       TGL_EN_P,
  output logic                       TGL_EN_N,
  output logic                       SLOW_LVL
);

  localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(RESET_PHASE);

  logic                      load;
  logic                      ce_ok;
  logic [DIV_W-1:0]          carry;
  logic [MAX_MATCH_BITS-1:0] match_ext;

`ifdef CLKEN_SYNC_EN
  clken_sync_fsm u_sync_fsm (
    .clk      (CLK),
    .reset    (RESETP),
    .ce_in_n  (CE_IN_N),
    .sync_req (SYNC_REQ),
    .load     (load),
    .sync_ack (SYNC_ACK)
  );
`else
  logic unused_sync;
  assign unused_sync = ^{SYNC_REQ, SYNC_PHASE};
  assign load        = 1'b0;
  assign SYNC_ACK    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESETP) begin
      DIV_CNT <= RST_CNT;
    end else if (load) begin
      DIV_CNT <= SYNC_PHASE;
    end else if (CE_IN_N) begin
      DIV_CNT <= DIV_CNT + 1'b1;
    end
  end

  // The load cycle is not a real divider step, so every enable is masked.
  assign ce_ok = CE_IN_N & ~load;

  // carry[k] is high when all bits below k are ones.
  for (genvar k = 0; k < DIV_W; k++) begin : g_tap
    if (k == 0) begin : g_lsb
      assign carry[k] = 1'b1;
    end else begin : g_upper
      assign carry[k] = carry[k-1] & DIV_CNT[k-1];
    end
    assign EN_RISE[k] = ce_ok & carry[k] & ~DIV_CNT[k];
    assign EN_FALL[k] = ce_ok & carry[k] &  DIV_CNT[k];
  end

  assign match_ext = MAX_MATCH_BITS'(MATCH_VAL);

  for (genvar i = 0; i < NUM_MATCH; i++) begin : g_match
    assign MATCH_EN[i] = ce_ok & (DIV_CNT == DIV_W'(match_slot(match_ext, i, DIV_W)));
  end

  always_ff @(posedge CLK) begin
    if (RESETP) begin
      TGL_CLK <= 1'b0;
    end else if (CE_IN_P) begin
      TGL_CLK <= ~TGL_CLK;
    end
  end

  assign TGL_EN_P = CE_IN_P & ~TGL_CLK;
  assign TGL_EN_N = CE_IN_P &  TGL_CLK;

  always_ff @(posedge CLK) begin
    if (RESETP) begin
      SLOW_LVL <= ~RST_CNT[DIV_W-1];
    end else if (EN_RISE[0]) begin
      SLOW_LVL <= ~DIV_CNT[DIV_W-1];
    end
  end

endmodule

// File: tb/tb_clken_divider_bank.sv
// Directed bench for clken_divider_bank with default parameters; the realign
// section is selected by CLKEN_SYNC_EN to match the build of the design.
module tb_clken_divider_bank;

  logic       CLK = 1'b0;
  logic       RESETP = 1'b1;
  logic       CE_IN_P = 1'b0;
  logic       CE_IN_N = 1'b0;
  logic       SYNC_REQ = 1'b0;
  logic [2:0] SYNC_PHASE = 3'd0;
  logic       SYNC_ACK;
  logic [5:0] MATCH_VAL = 6'b000_011;
  logic [2:0] DIV_CNT;
  logic [2:0] EN_RISE;
  logic [2:0] EN_FALL;
  logic [1:0] MATCH_EN;
  logic       TGL_CLK;
  logic       TGL_EN_P;
  logic       TGL_EN_N;
  logic       SLOW_LVL;

  int checks = 0;
  int errors = 0;

  clken_divider_bank #(.DIV_W(3), .NUM_MATCH(2), .RESET_PHASE(4)) dut (
    .CLK        (CLK),
    .RESETP     (RESETP),
    .CE_IN_P    (CE_IN_P),
    .CE_IN_N    (CE_IN_N),
    .SYNC_REQ   (SYNC_REQ),
    .SYNC_PHASE (SYNC_PHASE),
    .SYNC_ACK   (SYNC_ACK),
    .MATCH_VAL  (MATCH_VAL),
    .DIV_CNT    (DIV_CNT),
    .EN_RISE    (EN_RISE),
    .EN_FALL    (EN_FALL),
    .MATCH_EN   (MATCH_EN),
    .TGL_CLK    (TGL_CLK),
    .TGL_EN_P   (TGL_EN_P),
    .TGL_EN_N   (TGL_EN_N),
    .SLOW_LVL   (SLOW_LVL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle at the falling edge, then check the settled outputs.
  task automatic step(input logic cen, input logic req, input int ecnt,
                      input int erise, input int efall, input int ematch,
                      input int eslow, input int eack);
    @(negedge CLK);
    CE_IN_N  = cen;
    SYNC_REQ = req;
    #1;
    chk("div_cnt",  32'(DIV_CNT),  ecnt);
    chk("en_rise",  32'(EN_RISE),  erise);
    chk("en_fall",  32'(EN_FALL),  efall);
    chk("match_en", 32'(MATCH_EN), ematch);
    chk("slow_lvl", 32'(SLOW_LVL), eslow);
    chk("sync_ack", 32'(SYNC_ACK), eack);
  endtask

  task automatic ce_pair(input int c, input int erise, input int efall,
                         input int ematch, input int slow_b, input int slow_a);
    step(1'b1, 1'b0, c, erise, efall, ematch, slow_b, 0);
    step(1'b0, 1'b0, (c + 1) % 8, 0, 0, 0, slow_a, 0);
  endtask

  task automatic tgl_step(input logic cep, input int etgl, input int ep, input int en);
    @(negedge CLK);
    CE_IN_P = cep;
    #1;
    chk("tgl_clk",  32'(TGL_CLK),  etgl);
    chk("tgl_en_p", 32'(TGL_EN_P), ep);
    chk("tgl_en_n", 32'(TGL_EN_N), en);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETP = 1'b0;
    #1;
    chk("rst_div_cnt",  32'(DIV_CNT),  4);
    chk("rst_tgl_clk",  32'(TGL_CLK),  0);
    chk("rst_slow_lvl", 32'(SLOW_LVL), 0);
    chk("rst_sync_ack", 32'(SYNC_ACK), 0);
    chk("rst_en_rise",  32'(EN_RISE),  0);

    // Divider chain from reset phase 4 through one full wrap.
    ce_pair(4, 3'b001, 3'b000, 2'b00, 0, 0);
    ce_pair(5, 3'b010, 3'b001, 2'b00, 0, 0);
    ce_pair(6, 3'b001, 3'b000, 2'b00, 0, 0);
    ce_pair(7, 3'b000, 3'b111, 2'b00, 0, 0);
    ce_pair(0, 3'b001, 3'b000, 2'b10, 0, 1);
    ce_pair(1, 3'b010, 3'b001, 2'b00, 1, 1);
    ce_pair(2, 3'b001, 3'b000, 2'b00, 1, 1);
    ce_pair(3, 3'b100, 3'b011, 2'b01, 1, 1);
    ce_pair(4, 3'b001, 3'b000, 2'b00, 1, 0);

    // Toggle clock on CE_IN_P, divider idle.
    tgl_step(1'b1, 0, 1, 0);
    tgl_step(1'b0, 1, 0, 0);
    tgl_step(1'b1, 1, 0, 1);
    tgl_step(1'b0, 0, 0, 0);
    tgl_step(1'b1, 0, 1, 0);
    tgl_step(1'b0, 1, 0, 0);
    tgl_step(1'b1, 1, 0, 1);
    tgl_step(1'b0, 0, 0, 0);
    chk("div_cnt_idle", 32'(DIV_CNT), 5);

    ce_pair(5, 3'b010, 3'b001, 2'b00, 0, 0);

`ifdef CLKEN_SYNC_EN
    // One-cycle request at count 6, phase 2.
    SYNC_PHASE = 3'd2;
    step(1'b0, 1'b1, 6, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 6, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 2, 0, 0, 0, 0, 1);
    step(1'b0, 1'b0, 2, 0, 0, 0, 0, 0);

    // Load at an even count: SLOW_LVL must hold 0 instead of going to 1.
    SYNC_PHASE = 3'd5;
    step(1'b0, 1'b1, 2, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 2, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 5, 0, 0, 0, 0, 1);
    step(1'b0, 1'b0, 5, 0, 0, 0, 0, 0);

    // CE_IN_N on the IDLE->PEND cycle is a normal step; the next one loads.
    step(1'b1, 1'b1, 5, 3'b010, 3'b001, 0, 0, 0);
    SYNC_PHASE = 3'd1;
    step(1'b1, 1'b0, 6, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 1, 0, 0, 0, 0, 1);
    step(1'b0, 1'b0, 1, 0, 0, 0, 0, 0);

    // Reset while PEND aborts the request.
    step(1'b0, 1'b1, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESETP   = 1'b1;
    SYNC_REQ = 1'b0;
    CE_IN_N  = 1'b1;
    @(negedge CLK);
    RESETP  = 1'b0;
    CE_IN_N = 1'b0;
    #1;
    chk("abort_div_cnt",  32'(DIV_CNT),  4);
    chk("abort_sync_ack", 32'(SYNC_ACK), 0);
    step(1'b0, 1'b0, 4, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 4, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 4, 3'b001, 0, 0, 0, 0);
    step(1'b0, 1'b0, 5, 0, 0, 0, 0, 0);

    // Fresh request after reset completes.
    SYNC_PHASE = 3'd7;
    step(1'b0, 1'b1, 5, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 5, 0, 0, 0, 0, 0);
    step(1'b0, 1'b0, 7, 0, 0, 0, 0, 1);
    step(1'b0, 1'b0, 7, 0, 0, 0, 0, 0);

    // Request held high: load every other CE_IN_N, single-cycle acks.
    SYNC_PHASE = 3'd3;
    for (int s = 1; s <= 20; s++) begin
      int ecnt;
      int eack;
      int nrm;
      ecnt = (s < 3) ? 7 : (((s - 3) % 4 < 2) ? 3 : 4);
      eack = (s >= 3 && (s - 3) % 4 == 0) ? 1 : 0;
      nrm  = (s >= 4 && s % 4 == 0) ? 1 : 0;
      step(logic'(s % 2 == 0), 1'b1, ecnt, nrm ? 3'b100 : 0, nrm ? 3'b011 : 0,
           nrm ? 2'b01 : 0, 0, eack);
    end
    SYNC_REQ = 1'b0;
`else
    // Without the sync option the request inputs are ignored.
    SYNC_PHASE = 3'd2;
    step(1'b0, 1'b1, 6, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 6, 3'b001, 0, 0, 0, 0);
    step(1'b0, 1'b1, 7, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 7, 0, 3'b111, 0, 0, 0);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
